// File: rtl/mult_pkg.sv
// Shared state names and sizing helpers for the iterative arithmetic units.
// MULT_EARLY_TERM_EN (multiplier only) stops RUN once the multiplier runs out of set bits.
package mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder of N full-adder cells with carry-in tied low.
// Purely combinational; shared by every iteration of the multiplier.
module ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i])
                    | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier, one partial product per clock.
// Define MULT_EARLY_TERM_EN to leave RUN as soon as the shifted multiplier is zero.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]    sum;
  logic             cout_unused;
  logic [PW-1:0]    acc_nx;
  logic [WIDTH-1:0] mplier_nx;
  logic             last;

  ripple_adder #(.N(PW)) u_add (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .sum_o  (sum),
    .cout_o (cout_unused)
  );

  assign acc_nx    = mplier_q[0] ? sum : acc_q;
  assign mplier_nx = mplier_q >> 1;

`ifdef MULT_EARLY_TERM_EN
  assign last = (cnt_q == CW'(1)) || (mplier_nx == '0);
`else
  assign last = (cnt_q == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start so results can stream back-to-back
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, multiplicand};
          mplier_d = multiplier;
          cnt_d    = CW'(WIDTH);
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nx;
        cnt_d    = cnt_q - CW'(1);
        if (last) begin
          state_d = S_DONE;
          prod_d  = acc_nx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized bench for shift_add_multiplier against an arithmetic model.
// Expected latency follows MULT_EARLY_TERM_EN when the bench is built with it.
module tb_shift_add_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int            n_vec = 0;
  int            n_bad = 0;
  int unsigned   qa[$];
  int unsigned   qb[$];
  logic [PW-1:0] last_prod = '0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // iterations needed for multiplier b
  function automatic int lat(input int unsigned b);
    int n = 1;
    for (int i = 0; i < W; i++)
      if (b[i]) n = i + 1;
`ifndef MULT_EARLY_TERM_EN
    n = W;
`endif
    return n;
  endfunction

  // runs every queued op with start held high between them
  task automatic stream();
    int n     = qa.size();
    int pend  = 0;
    int k     = 0;
    int guard = 0;
    logic [PW-1:0] exp;
    mcand  = W'(qa[0]);
    mplier = W'(qb[0]);
    start  = 1'b1;
    @(negedge clk);
    while (pend < n && guard < n * (W + 2) + 4) begin
      if (k == 0) begin
        if (pend + 1 < n) begin
          mcand  = W'(qa[pend+1]);
          mplier = W'(qb[pend+1]);
          start  = 1'b1;
        end else begin
          start  = 1'b0;
          mcand  = W'($urandom);
          mplier = W'($urandom);
        end
      end
      if (done) begin
        exp = PW'(qa[pend] * qb[pend]);
        chk("product", product, exp);
        chk("latency", k, lat(qb[pend]));
        last_prod = exp;
        pend++;
        k = -1;
      end else begin
        chk("busy", busy, 1);
        chk("hold_run", product, last_prod);
      end
      @(negedge clk);
      k++;
      guard++;
    end
    chk("done_count", pend, n);
    start = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      start  = 1'b0;
      mcand  = W'($urandom);
      mplier = W'($urandom);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_hold", product, last_prod);
      @(negedge clk);
    end
  endtask

  function automatic int unsigned pick();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return (1 << W) - 1;
      2:       return $urandom_range(0, 255) >> $urandom_range(0, 7);
      default: return $urandom_range(0, (1 << W) - 1);
    endcase
  endfunction

  initial begin
    int cnt;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);

    qa.push_back(13);  qb.push_back(11);  stream(); idle(2);
    qa.push_back(255); qb.push_back(255); stream(); idle(1);
    qa.push_back(0);   qb.push_back(77);  stream(); idle(1);
    qa.push_back(200); qb.push_back(1);   stream(); idle(1);
    qa.push_back(3);   qb.push_back(128); stream(); idle(1);

    qa.push_back(3);   qb.push_back(7);
    qa.push_back(5);   qb.push_back(9);
    qa.push_back(200); qb.push_back(2);
    stream();
    idle(2);

    // reset during the 4th RUN cycle of 100*100
    mcand  = 8'd100;
    mplier = 8'd100;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_prod", product, 0);
    last_prod = '0;
    cnt = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_done", cnt, 0);

    repeat (300) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        qa.push_back(pick());
        qb.push_back(pick());
      end
      stream();
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
